gate_power_monitor: RTL
=======================

// Module: gate_power_monitor
// PURPOSE
//  Clocked stage directly downstream of a library gate model (Nor/Nand/Not family).
//  Samples the gate output Q and counts its transitions over a programmable window of clk cycles.
//  Energy per transition is E = VDD_V^2 * CAP_PF, in pJ. The monitor accumulates transition count and energy.
//  It reports both through a valid/ready handshake, so testbenches read power figures cycle-accurately.
// PARAMETERS
//  VDD_V     10  supply voltage, integer volts (per gate datasheet)
//  CAP_PF    50  load capacitance, integer pF; E_TOGGLE = VDD_V*VDD_V*CAP_PF pJ (default 5000)
//  CNT_W     16  width of toggle_count
//  ENERGY_W  32  width of energy_pj
//  WIN_W     16  width of window_len
// PORTS
//  clk           in   1         single clock, all state updates on posedge
//  reset_L       in   1         synchronous, active-low reset
//  gate_q        in   1         Q output of monitored gate, asynchronous to clk
//  start         in   1         begin a measurement (accepted only in IDLE)
//  abort         in   1         cancel measurement in ARM/MEASURE
//  window_len    in   WIN_W     number of MEASURE cycles; sampled when start accepted
//  busy          out  1         1 in ARM or MEASURE
//  toggle_count  out  CNT_W     transitions counted in current/last window
//  energy_pj     out  ENERGY_W  accumulated energy, pJ
//  saturated     out  1         either accumulator clipped this window
//  result_valid  out  1         result available (REPORT state)
//  result_ready  in   1         consumer accepts result
// BEHAVIOUR
//  Reset (reset_L=0 at posedge): state=IDLE, sync/prev flops=0. busy, toggle_count, energy_pj,
//    saturated and result_valid are all 0. Reset overrides every other input, in any state.
//  Input path: gate_q -> sync1 -> sync2 (2-flop synchronizer, always running).
//    toggle = sync2 ^ prev. An edge on gate_q is visible as toggle 2-3 cycles later.
//  FSM states: IDLE, ARM, MEASURE, REPORT.
//  IDLE: start=1 && window_len!=0 -> ARM and latch remaining<=window_len.
//    start with window_len==0 is ignored.
//    Outputs keep the last result (result_valid=0).
//  ARM (1 cycle): prev<=sync2; toggle_count, energy_pj, saturated <= 0; busy=1 -> MEASURE.
//  MEASURE: every cycle prev<=sync2 and remaining<=remaining-1.
//    If toggle: toggle_count += 1 and energy_pj += E_TOGGLE.
//    remaining==1 -> REPORT next cycle, so exactly window_len cycles are sampled.
//    The count in the final cycle is included.
//  Arithmetic: each accumulator saturates independently at all-ones. Clipping either one sets saturated (sticky per window).
//    E_TOGGLE is a localparam; it must fit ENERGY_W (elaboration-time check).
//  REPORT: result_valid=1, busy=0. toggle_count, energy_pj and saturated hold stable.
//    result_valid && result_ready at posedge -> IDLE; result_valid falls next cycle.
//    start is ignored while in REPORT.
//  abort=1 in ARM/MEASURE -> IDLE next cycle. Partial counts are left visible, result_valid never asserted.
//    abort in IDLE/REPORT has no effect. start is ignored in ARM/MEASURE.
//  Simultaneous start+abort in IDLE: start wins (abort is ignored in IDLE).
//  toggle_count/energy_pj update live during MEASURE; the consumer must treat them as final only when result_valid=1.
// TESTING
//  1 Reset: reset_L=0 for 3 cycles while gate_q toggles, start=1.
//    -> all outputs 0, state IDLE, and no ARM on the cycle reset releases.
//  2 Toggle every cycle: gate_q flips each clk, window_len=8, start pulse.
//    -> result_valid 10 cycles after start accepted (ARM + 8 MEASURE + REPORT entry),
//       toggle_count=8, energy_pj=40000.
//  3 Static input: gate_q=1 constant, window_len=16.
//    -> toggle_count=0, energy_pj=0, saturated=0.
//  4 Saturation: CNT_W=4, gate_q toggling every cycle, window_len=20.
//    -> toggle_count=15, saturated=1, energy_pj=100000.
//  5 Handshake: result_ready=0 for 5 cycles in REPORT, start pulsed there.
//    -> outputs stable, start ignored. result_ready=1 -> IDLE, result_valid=0 next cycle.
//  6 Mid-window: abort at MEASURE cycle 3 -> IDLE, no result_valid.
//    Then reset_L=0 mid-MEASURE -> all outputs 0 next cycle.

Source files
------------

// File: rtl/gate_power_monitor.sv
// -----------------------------------------------------------------------------
// gate_power_monitor
//
// Purpose:
//   Clocked stage placed directly after a library gate model. It samples the
//   gate output through a two-flop synchronizer and counts transitions over a
//   programmable window of clk cycles. Each transition costs
//   E_TOGGLE = VDD_V^2 * CAP_PF picojoules. Both accumulators saturate at
//   all-ones. A valid/ready handshake presents the finished result.
//
// Ports:
//   clk           in   1         single clock, all state on posedge
//   reset_L       in   1         synchronous, active-low reset
//   gate_q        in   1         monitored gate output, asynchronous to clk
//   start         in   1         begin a measurement (IDLE only)
//   abort         in   1         cancel a measurement (ARM/MEASURE only)
//   window_len    in   WIN_W     MEASURE cycles, latched when start accepted
//   busy          out  1         high in ARM or MEASURE
//   toggle_count  out  CNT_W     transitions in current/last window
//   energy_pj     out  ENERGY_W  accumulated energy in pJ
//   saturated     out  1         an accumulator clipped during this window
//   result_valid  out  1         result available (REPORT)
//   result_ready  in   1         consumer accepts the result
// -----------------------------------------------------------------------------
module gate_power_monitor #(
  parameter int VDD_V    = 10,
  parameter int CAP_PF   = 50,
  parameter int CNT_W    = 16,
  parameter int ENERGY_W = 32,
  parameter int WIN_W    = 16
) (
  input  logic                clk,
  input  logic                reset_L,
  input  logic                gate_q,
  input  logic                start,
  input  logic                abort,
  input  logic [WIN_W-1:0]    window_len,
  output logic                busy,
  output logic [CNT_W-1:0]    toggle_count,
  output logic [ENERGY_W-1:0] energy_pj,
  output logic                saturated,
  output logic                result_valid,
  input  logic                result_ready
);

  // Energy per transition, computed wide so the range check below is exact.
  localparam logic [63:0] E_TOGGLE_WIDE = 64'(VDD_V) * 64'(VDD_V) * 64'(CAP_PF);
  localparam logic [ENERGY_W-1:0] E_TOGGLE = E_TOGGLE_WIDE[ENERGY_W-1:0];
  // Largest energy value that can still absorb one more transition unclipped.
  localparam logic [ENERGY_W-1:0] ENERGY_HEADROOM = {ENERGY_W{1'b1}} - E_TOGGLE;

  generate
    if ((ENERGY_W < 64) && ((E_TOGGLE_WIDE >> ENERGY_W) != 64'd0)) begin : g_energy_check
      $error("gate_power_monitor: VDD_V^2*CAP_PF does not fit in ENERGY_W bits");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2,
    REPORT  = 2'd3
  } state_t;

  state_t              state_reg, state_next;
  logic [WIN_W-1:0]    remaining_reg, remaining_next;
  logic [CNT_W-1:0]    count_reg, count_next;
  logic [ENERGY_W-1:0] energy_reg, energy_next;
  logic                sat_reg, sat_next;

  // sync_reg[0] is the metastability-catching stage, sync_reg[1] the
  // stable sample. prev_reg holds the previous stable sample.
  logic [1:0]          sync_reg;
  logic                prev_reg;
  logic                toggle;

  assign toggle = sync_reg[1] ^ prev_reg;

  // Synchronizer and edge-detect history run in every state. prev_reg
  // tracking sync_reg[1] continuously gives the same result as reloading it
  // in ARM, so the first MEASURE cycle never sees a stale edge.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      sync_reg <= 2'b00;
      prev_reg <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], gate_q};
      prev_reg <= sync_reg[1];
    end
  end

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    count_next     = count_reg;
    energy_next    = energy_reg;
    sat_next       = sat_reg;

    case (state_reg)
      IDLE: begin
        // A zero-length window is not a measurement; ignore it.
        if (start && (window_len != '0)) begin
          state_next     = ARM;
          remaining_next = window_len;
        end
      end

      ARM: begin
        count_next  = '0;
        energy_next = '0;
        sat_next    = 1'b0;
        state_next  = abort ? IDLE : MEASURE;
      end

      MEASURE: begin
        remaining_next = remaining_reg - WIN_W'(1);
        if (toggle) begin
          if (count_reg == {CNT_W{1'b1}}) begin
            sat_next = 1'b1;
          end else begin
            count_next = count_reg + CNT_W'(1);
          end
          if (energy_reg > ENERGY_HEADROOM) begin
            energy_next = {ENERGY_W{1'b1}};
            sat_next    = 1'b1;
          end else begin
            energy_next = energy_reg + E_TOGGLE;
          end
        end
        // Abort beats window completion: an aborted window never reports.
        if (abort) begin
          state_next = IDLE;
        end else if (remaining_reg == WIN_W'(1)) begin
          state_next = REPORT;
        end
      end

      REPORT: begin
        if (result_ready) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      count_reg     <= '0;
      energy_reg    <= '0;
      sat_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      count_reg     <= count_next;
      energy_reg    <= energy_next;
      sat_reg       <= sat_next;
    end
  end

  assign busy         = (state_reg == ARM) || (state_reg == MEASURE);
  assign result_valid = (state_reg == REPORT);
  assign toggle_count = count_reg;
  assign energy_pj    = energy_reg;
  assign saturated    = sat_reg;

endmodule
